param_ram: RTL and testbench

- Synchronous parameter (weight/bias) memory that answers the RAM read/write bus driven by a network layer.
- Read data appears exactly RAM_DELAY enabled cycles after the address is sampled, which is the latency the layer counts with its delay counter.
- One write port and one read port.
- Built-in clear sequencer zeroes the whole array after reset or on request.
- Sits between a layer (the requester) and the weight storage.

---
 rtl/param_ram.sv | 104 ++++++++++
 tb/tb_param_ram.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_ram.sv
// param_ram: parameter memory with pipelined reads and a built-in clear sequencer.
// Define PARAM_RAM_BYPASS_EN for write-first same-address read behaviour.
module param_ram #(
    parameter int NUM_W      = 16,
    parameter int RAM_ADDR_W = 8,
    parameter int DEPTH      = 2**RAM_ADDR_W,
    parameter int RAM_DELAY  = 3
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  enable,
    input  logic                  ram_write,
    input  logic [RAM_ADDR_W-1:0] ram_addr_write,
    input  logic [NUM_W-1:0]      ram_data_write,
    input  logic [RAM_ADDR_W-1:0] ram_addr_read,
    output logic [NUM_W-1:0]      ram_data_read,
    input  logic                  clear_req,
    output logic                  init_busy
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [RAM_ADDR_W-1:0] LAST = RAM_ADDR_W'(DEPTH - 1);

    logic [NUM_W-1:0]      mem  [DEPTH];
    logic [NUM_W-1:0]      pipe [RAM_DELAY];
    state_t                state, state_n;
    logic [RAM_ADDR_W-1:0] ptr, ptr_n, waddr;
    logic [NUM_W-1:0]      wdata, rd_word;
    logic                  we, wr_ok, rd_ok;

    assign wr_ok = int'(ram_addr_write) < DEPTH;
    assign rd_ok = int'(ram_addr_read) < DEPTH;

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        we      = 1'b0;
        waddr   = ram_addr_write;
        wdata   = ram_data_write;
        if (enable) begin
            unique case (state)
                CLEAR: begin
                    we    = 1'b1;
                    waddr = ptr;
                    wdata = '0;
                    ptr_n = ptr + 1'b1;
                    if (ptr == LAST) begin
                        state_n = IDLE;
                        ptr_n   = '0;
                    end
                end
                IDLE: begin
                    // A clear request drops any write issued alongside it
                    if (clear_req) begin
                        state_n = CLEAR;
                        ptr_n   = '0;
                    end else begin
                        we = ram_write && wr_ok;
                    end
                end
                default: state_n = CLEAR;
            endcase
        end
    end

    always_comb begin
        rd_word = rd_ok ? mem[ram_addr_read] : '0;
`ifdef PARAM_RAM_BYPASS_EN
        if (we && waddr == ram_addr_read)
            rd_word = wdata;
`endif
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < RAM_DELAY; i++)
                pipe[i] <= '0;
        end else if (enable) begin
            pipe[0] <= rd_word;
            for (int i = 1; i < RAM_DELAY; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign init_busy     = (state == CLEAR);
    assign ram_data_read = init_busy ? '0 : pipe[RAM_DELAY-1];

endmodule

// File: tb/tb_param_ram.sv
// tb_param_ram: randomized and directed checks of param_ram
// against a behavioural memory model kept in the bench.
module tb_param_ram;

    localparam int NW = 16;
    localparam int AW = 8;
    localparam int DP = 256;
    localparam int RD = 3;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          enable = 1'b1;
    logic          ram_write = 1'b0;
    logic [AW-1:0] ram_addr_write = '0;
    logic [NW-1:0] ram_data_write = '0;
    logic [AW-1:0] ram_addr_read = '0;
    logic [NW-1:0] ram_data_read;
    logic          clear_req = 1'b0;
    logic          init_busy;

    int checks = 0;
    int failures = 0;

    param_ram #(
        .NUM_W(NW), .RAM_ADDR_W(AW), .DEPTH(DP), .RAM_DELAY(RD)
    ) dut (
        .clk(clk),
        .nreset(nreset),
        .enable(enable),
        .ram_write(ram_write),
        .ram_addr_write(ram_addr_write),
        .ram_data_write(ram_data_write),
        .ram_addr_read(ram_addr_read),
        .ram_data_read(ram_data_read),
        .clear_req(clear_req),
        .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: array memory, clear countdown, queue of read results
    logic [NW-1:0] mmem [DP];
    logic [NW-1:0] mq   [RD];
    bit            mbusy = 1'b1;
    int            mptr  = 0;

    initial for (int i = 0; i < DP; i++) mmem[i] = '0;

    always @(posedge clk or negedge nreset) begin
        logic [NW-1:0] rv;
        if (!nreset) begin
            mbusy = 1'b1;
            mptr  = 0;
            for (int i = 0; i < RD; i++) mq[i] = '0;
        end else if (enable) begin
            rv = (int'(ram_addr_read) < DP) ? mmem[ram_addr_read] : '0;
`ifdef PARAM_RAM_BYPASS_EN
            if (mbusy && int'(ram_addr_read) == mptr)
                rv = '0;
            else if (!mbusy && !clear_req && ram_write &&
                     ram_addr_write == ram_addr_read)
                rv = ram_data_write;
`endif
            if (mbusy) begin
                mmem[mptr] = '0;
                mptr = mptr + 1;
                if (mptr == DP) begin
                    mbusy = 1'b0;
                    mptr  = 0;
                end
            end else if (clear_req) begin
                mbusy = 1'b1;
                mptr  = 0;
            end else if (ram_write && int'(ram_addr_write) < DP) begin
                mmem[ram_addr_write] = ram_data_write;
            end
            for (int i = RD - 1; i > 0; i--) mq[i] = mq[i-1];
            mq[0] = rv;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic [NW-1:0] exp;
        exp = mbusy ? '0 : mq[RD-1];
        checks++;
        if (ram_data_read !== exp) begin
            failures++;
            $display("FAIL model_data t=%0t got=%h exp=%h",
                     $time, ram_data_read, exp);
        end
        checks++;
        if (init_busy !== mbusy) begin
            failures++;
            $display("FAIL model_busy t=%0t got=%b exp=%b",
                     $time, init_busy, mbusy);
        end
    end

    task automatic lit(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic count_busy(input string nm);
        int n;
        n = 0;
        while (init_busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        lit(nm, n, 256);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [NW-1:0] d);
        ram_write = 1'b1;
        ram_addr_write = a;
        ram_data_write = d;
        step(1);
        ram_write = 1'b0;
    endtask

    task automatic rd_check(input string nm, input logic [AW-1:0] a,
                            input logic [NW-1:0] e);
        ram_addr_read = a;
        step(RD);
        lit(nm, int'(ram_data_read), int'(e));
    endtask

    initial begin
        logic [NW-1:0] same_exp;
        step(3);
        lit("reset_data", int'(ram_data_read), 0);
        lit("reset_busy", int'(init_busy), 1);
        nreset = 1'b1;
        count_busy("clear_len_initial");
        rd_check("rd0_zero", 8'd0, 16'h0000);
        rd_check("rd100_zero", 8'd100, 16'h0000);
        rd_check("rd255_zero", 8'd255, 16'h0000);

        wr(8'd5, 16'h0180);
        ram_addr_read = 8'd5;
        step(RD - 1);
        lit("before_0180", int'(ram_data_read), 0);
        step(1);
        lit("latency_0180", int'(ram_data_read), 16'h0180);

        for (int i = 0; i < 4; i++) wr(AW'(i), NW'(i + 1));
        for (int i = 0; i < 6; i++) begin
            if (i < 4) ram_addr_read = AW'(3 - i);
            step(1);
            if (i >= 2) lit("stream", int'(ram_data_read), 6 - i);
        end

        wr(8'd7, 16'h1111);
`ifdef PARAM_RAM_BYPASS_EN
        same_exp = 16'h2222;
`else
        same_exp = 16'h1111;
`endif
        ram_addr_read = 8'd7;
        wr(8'd7, 16'h2222);
        step(RD - 1);
        lit("same_edge", int'(ram_data_read), int'(same_exp));
        step(1);
        lit("after_same", int'(ram_data_read), 16'h2222);

        for (int i = 0; i < 10; i++) begin
            ram_addr_read = AW'(i % 4);
            enable = !(i >= 4 && i < 8);
            ram_write = !enable;
            ram_addr_write = 8'd2;
            ram_data_write = 16'hDEAD;
            step(1);
            if (i >= 3 && i <= 7) lit("en_hold", int'(ram_data_read), 2);
            if (i == 8) lit("en_resume0", int'(ram_data_read), 3);
            if (i == 9) lit("en_resume1", int'(ram_data_read), 4);
        end
        enable = 1'b1;
        ram_write = 1'b0;
        rd_check("en_nowrite", 8'd2, 16'h0003);

        wr(8'd9, 16'h0ABC);
        rd_check("pre_clear9", 8'd9, 16'h0ABC);
        ram_addr_read = 8'd0;
        clear_req = 1'b1;
        wr(8'd9, 16'h0555);
        clear_req = 1'b0;
        count_busy("clear_len_req");
        rd_check("post_clear9", 8'd9, 16'h0000);

        wr(8'd1, 16'h7777);
        rd_check("pre_reset", 8'd1, 16'h7777);
        #2 nreset = 1'b0;
        #1 lit("midread_rst_data", int'(ram_data_read), 0);
        lit("midread_rst_busy", int'(init_busy), 1);
        ram_addr_read = 8'd0;
        @(negedge clk) nreset = 1'b1;
        count_busy("clear_len_rst1");

        clear_req = 1'b1;
        step(1);
        clear_req = 1'b0;
        step(100);
        #2 nreset = 1'b0;
        #1 lit("midclear_rst_data", int'(ram_data_read), 0);
        @(negedge clk) nreset = 1'b1;
        count_busy("clear_len_rst2");

        for (int i = 0; i < 2000; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            ram_write = $urandom_range(0, 1);
            ram_addr_write = AW'($urandom_range(0, 15));
            ram_data_write = NW'($urandom);
            ram_addr_read = AW'($urandom_range(0, 15));
            step(1);
        end
        enable = 1'b1;
        ram_write = 1'b0;
        step(RD + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
